// File: rtl/btn_edge_poller_pkg.sv
// Shared definitions for the button edge poller: PIO register offsets, poller
// state encoding, CPU slave map and event record layout.
package pio_defs;

  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

  localparam logic [1:0] S_EVENT  = 2'd0;
  localparam logic [1:0] S_STATUS = 2'd1;
  localparam logic [1:0] S_CTRL   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_GAP    = 3'd5
  } poll_state_t;

  // Event record: {seq[7:0], id[3:0]}
  localparam int EV_ID_LSB  = 0;
  localparam int EV_ID_W    = 4;
  localparam int EV_SEQ_LSB = 4;
  localparam int EV_SEQ_W   = 8;
  localparam int EV_W       = EV_SEQ_W + EV_ID_W;

  function automatic logic [31:0] event_word(input logic [EV_W-1:0] rec);
    return {1'b1, 15'h0, rec[EV_SEQ_LSB +: EV_SEQ_W], 4'h0, rec[EV_ID_LSB +: EV_ID_W]};
  endfunction

endpackage

// File: rtl/btn_edge_poller_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit to tell full from empty.
module btn_event_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/btn_edge_poller.sv
// Round-robin poller of button PIO edge-capture registers, with a queued event
// FIFO and IRQ exposed to the CPU through a small Avalon-MM slave.
//
// state  | meaning
// IDLE   | polling disabled, idx held
// SETUP  | select PIO idx, edge-capture offset, read
// SAMPLE | capture bit0 of the selected readdata slice
// CLEAR  | write 0 to edge capture, enqueue {seq, idx}
// NEXT   | advance idx, wrap into GAP after the last PIO
// GAP    | idle POLL_GAP cycles between sweeps
module btn_edge_poller
  import pio_defs::*;
#(
  parameter int N_PIO      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_GAP   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [N_PIO-1:0]    m_chipselect,
  output logic [1:0]          m_address,
  output logic                m_write_n,
  output logic [31:0]         m_writedata,
  input  logic [N_PIO*32-1:0] m_readdata,
  input  logic                s_chipselect,
  input  logic [1:0]          s_address,
  input  logic                s_read,
  input  logic                s_write_n,
  input  logic [31:0]         s_writedata,
  output logic [31:0]         s_readdata,
  output logic                irq
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int          GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);
  localparam logic [3:0]  LAST_IDX = 4'(N_PIO - 1);

  poll_state_t   state, state_nx;
  logic [3:0]    idx, idx_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [7:0]    seq;
  logic          enable;
  logic          irq_en;
  logic          overflow;
  logic          edge_sel;
  logic          push;
  logic          active_nx;

  logic            s_rd;
  logic            s_wr;
  logic            pop;
  logic [31:0]     rd_word;
  logic [EV_W-1:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [7:0]      cnt8;

  logic unused_bits;
  assign unused_bits = ^{m_readdata, s_writedata[31:2]};

  always_comb begin
    edge_sel = 1'b0;
    for (int i = 0; i < N_PIO; i++) begin
      if (idx == 4'(i)) edge_sel = m_readdata[32*i];
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    gap_nx   = gap_cnt;
    push     = 1'b0;
    case (state)
      ST_IDLE:   if (enable) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_SAMPLE;
      ST_SAMPLE: begin
        // A set capture is always cleared, even if polling was just disabled.
        if (edge_sel)     state_nx = ST_CLEAR;
        else if (!enable) state_nx = ST_IDLE;
        else              state_nx = ST_NEXT;
      end
      ST_CLEAR: begin
        push     = 1'b1;
        state_nx = enable ? ST_NEXT : ST_IDLE;
      end
      ST_NEXT: begin
        if (idx == LAST_IDX) begin
          idx_nx   = 4'd0;
          gap_nx   = GAP_LOAD;
          state_nx = ST_GAP;
        end else begin
          idx_nx   = idx + 4'd1;
          state_nx = enable ? ST_SETUP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_nx = enable ? ST_SETUP : ST_IDLE;
        else               gap_nx   = gap_cnt - GW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign active_nx = (state_nx == ST_SETUP) || (state_nx == ST_SAMPLE) ||
                     (state_nx == ST_CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      gap_cnt <= '0;
      seq     <= 8'd0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      gap_cnt <= gap_nx;
      if (push) seq <= seq + 8'd1;
    end
  end

  // Master outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_chipselect <= '0;
      m_address    <= PIO_DATA;
      m_write_n    <= 1'b1;
      m_writedata  <= 32'h0;
    end else begin
      for (int i = 0; i < N_PIO; i++) begin
        m_chipselect[i] <= active_nx && (idx_nx == 4'(i));
      end
      m_address   <= active_nx ? PIO_EDGE : PIO_DATA;
      m_write_n   <= (state_nx != ST_CLEAR);
      m_writedata <= 32'h0;
    end
  end

  btn_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({seq, idx}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign s_rd = s_chipselect & s_read;
  assign s_wr = s_chipselect & ~s_write_n;
  assign pop  = s_rd && (s_address == S_EVENT) && !fifo_empty;
  assign cnt8 = 8'(fifo_count);

  always_comb begin
    rd_word = 32'h0;
    case (s_address)
      S_EVENT:  if (!fifo_empty) rd_word = event_word(fifo_rdata);
      S_STATUS: rd_word = {16'h0, cnt8, 6'h0, overflow, ~fifo_empty};
      S_CTRL:   rd_word = {30'h0, irq_en, enable};
      default:  rd_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= 32'h0;
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s_readdata <= s_rd ? rd_word : 32'h0;
      if (s_wr && (s_address == S_CTRL)) begin
        enable <= s_writedata[0];
        irq_en <= s_writedata[1];
      end
      // A drop in the same cycle as a software clear keeps overflow set.
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
      else if (s_wr && (s_address == S_STATUS) && s_writedata[1])
        overflow <= 1'b0;
    end
  end

  assign irq = irq_en & ~fifo_empty;

endmodule
